midori_rand_gen: RTL and testbench

Fresh-randomness generator for the masked Midori S-box layer. It sits directly upstream of the second-order three-share F stage and feeds it the 18-bit `r` and 6-bit `rs` refresh inputs for every S-box instance. A bank of reseedable 31-bit LFSR lanes is advanced 24 steps per enabled cycle. The bank is gated by a seed handshake and a warm-up phase, so the S-box pipeline never consumes unseeded or warm-up bits.

---
 rtl/midori_rand_gen.sv | 166 ++++++++++++++++
 tb/tb_midori_rand_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midori_rand_gen.sv
// Fresh-randomness source for the masked Midori S-box layer.
// A bank of NUM_SBOX reseedable 31-bit LFSR lanes, each advanced 24 steps per
// enabled cycle. Each lane's 24-bit word feeds one S-box: bits [17:0] go to its
// r input and bits [23:18] go to its rs input. After every seed handshake the
// bank runs WARM+1 forced advances. It only raises rnd_valid_o on the last of
// these advances, so warm-up bits never reach the pipeline.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   seed_valid_i  seed offered
//   seed_i        31-bit seed
//   seed_ready_o  seed accepted on this cycle's edge if seed_valid_i is high
//   en_i          advance request from the S-box pipeline (RUN only)
//   rnd_valid_o   r_out_o / rs_out_o hold a valid fresh word
//   r_out_o       lane i drives [18i+17:18i]
//   rs_out_o      lane i drives [6i+5:6i]
module midori_rand_gen #(
  parameter int unsigned NUM_SBOX = 16,
  parameter int unsigned WARM     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seed_valid_i,
  input  logic [30:0]              seed_i,
  output logic                     seed_ready_o,
  input  logic                     en_i,
  output logic                     rnd_valid_o,
  output logic [NUM_SBOX*18-1:0]   r_out_o,
  output logic [NUM_SBOX*6-1:0]    rs_out_o
);

  localparam int unsigned CntW      = $clog2(WARM + 2);
  localparam logic [30:0] LaneConst = 31'h2545F491;

  function automatic logic [30:0] rotl31(input logic [30:0] v, input int unsigned n);
    return 31'({v, v} >> (31 - n));
  endfunction

  // 24 unrolled steps of fb = s[30]^s[27]; returns {next_state, word}.
  function automatic logic [54:0] advance24(input logic [30:0] s);
    logic [30:0] st;
    logic [23:0] w;
    logic        fb;
    st = s;
    w  = '0;
    for (int k = 0; k < 24; k++) begin
      fb   = st[30] ^ st[27];
      w[k] = fb;
      st   = {st[29:0], fb};
    end
    return {st, w};
  endfunction

  typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            hs;
  logic            load;
  logic            adv_en;

  // ready_q is registered so it reads 0 while in reset and has no input path.
  assign hs = seed_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    load    = 1'b0;
    adv_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          load    = 1'b1;
          cnt_d   = CntW'(WARM + 1);
          state_d = StWarm;
          valid_d = 1'b0;
        end
      end
      StWarm: begin
        adv_en = 1'b1;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
          valid_d = 1'b1;
        end
      end
      StRun: begin
        // Reseed takes priority over an advance on the same edge.
        if (hs) begin
          load    = 1'b1;
          cnt_d   = CntW'(WARM + 1);
          state_d = StWarm;
          valid_d = 1'b0;
        end else if (en_i) begin
          adv_en = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d != StWarm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign seed_ready_o = ready_q;
  assign rnd_valid_o  = valid_q;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    localparam logic [30:0] LaneRot = rotl31(LaneConst, i);

    logic [30:0] lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic [30:0] ls_raw;
    logic [30:0] ls;
    logic [54:0] adv;

    assign ls_raw = seed_i ^ LaneRot;
    // An all-zero LFSR would lock up; substitute a non-zero seed.
    assign ls     = (ls_raw == '0) ? 31'h1 : ls_raw;
    assign adv    = advance24(lane_q);

    always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (load) begin
        lane_d = ls;
      end else if (adv_en) begin
        lane_d = adv[54:24];
        word_d = adv[23:0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
        word_q <= '0;
      end else begin
        lane_q <= lane_d;
        word_q <= word_d;
      end
    end

    assign r_out_o[18*i +: 18] = word_q[17:0];
    assign rs_out_o[6*i +: 6]  = word_q[23:18];
  end

endmodule

// File: tb/tb_midori_rand_gen.sv
module tb_midori_rand_gen;

  localparam int NL = 16;
  localparam int W  = 4;
  localparam int HL = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              seed_valid;
  logic [30:0]       seed;
  logic              seed_ready;
  logic              en;
  logic              rnd_valid;
  logic [NL*18-1:0]  r_out;
  logic [NL*6-1:0]   rs_out;

  logic              s_seed_valid;
  logic [30:0]       s_seed;
  logic              s_seed_ready;
  logic              s_en;
  logic              s_rnd_valid;
  logic [17:0]       s_r_out;
  logic [5:0]        s_rs_out;

  midori_rand_gen #(.NUM_SBOX(NL), .WARM(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .seed_ready_o (seed_ready),
    .en_i         (en),
    .rnd_valid_o  (rnd_valid),
    .r_out_o      (r_out),
    .rs_out_o     (rs_out)
  );

  midori_rand_gen #(.NUM_SBOX(1), .WARM(1)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_valid_i (s_seed_valid),
    .seed_i       (s_seed),
    .seed_ready_o (s_seed_ready),
    .en_i         (s_en),
    .rnd_valid_o  (s_rnd_valid),
    .r_out_o      (s_r_out),
    .rs_out_o     (s_rs_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each lane is the bit sequence b[n] = b[n-31] ^ b[n-28],
  // whose first 31 entries are the lane seed read oldest-first (bit 30 first).
  bit          hist [NL][HL];
  int          mlen;
  logic [23:0] mw [NL];
  logic [NL*18-1:0] exp_r;
  logic [NL*6-1:0]  exp_rs;

  logic [30:0] reseed_val;
  logic [NL*18-1:0] cap_r  [6];
  logic [NL*6-1:0]  cap_rs [6];

  function automatic logic [30:0] model_lane_seed(input logic [30:0] s, input int i);
    longint unsigned c;
    longint unsigned rot;
    logic [30:0]     v;
    c   = 64'h2545F491;
    rot = ((c << i) | (c >> (31 - i))) & 64'h7FFF_FFFF;
    v   = s ^ rot[30:0];
    if (v == 31'h0) v = 31'h1;
    return v;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) mw[l] = 24'h0;
    mlen = 0;
  endtask

  task automatic model_seed(input logic [30:0] s);
    logic [30:0] ls;
    for (int l = 0; l < NL; l++) begin
      ls = model_lane_seed(s, l);
      for (int j = 0; j < 31; j++) hist[l][j] = ls[30-j];
    end
    mlen = 31;
  endtask

  task automatic model_adv();
    bit b;
    if (mlen + 24 >= HL) begin
      $display("FAIL model_capacity: got mlen=%0d required below %0d", mlen, HL - 24);
      $fatal(1);
    end
    for (int k = 0; k < 24; k++) begin
      for (int l = 0; l < NL; l++) begin
        b = hist[l][mlen-31] ^ hist[l][mlen-28];
        hist[l][mlen] = b;
        mw[l][k] = b;
      end
      mlen++;
    end
  endtask

  task automatic model_pack();
    for (int l = 0; l < NL; l++) begin
      exp_r[18*l +: 18] = mw[l][17:0];
      exp_rs[6*l +: 6]  = mw[l][23:18];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a seed once seed_ready is seen (bounded wait), completing one handshake.
  task automatic do_seed(input logic [30:0] s, input logic en_val);
    int t;
    t = 0;
    while (seed_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_ready_wait: got %b required 1 within 20 cycles", seed_ready);
    end
    seed_valid = 1'b1;
    seed       = s;
    en         = en_val;
    tick();
    seed_valid = 1'b0;
    en         = 1'b0;
    model_seed(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({rnd_valid, seed_ready, r_out, rs_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ready=%b r=%h rs=%h required all 0",
               rnd_valid, seed_ready, r_out, rs_out);
    end
    n_checks++;
    if ({s_rnd_valid, s_seed_ready, s_r_out, s_rs_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got valid=%b ready=%b r=%h rs=%h required all 0",
               s_rnd_valid, s_seed_ready, s_r_out, s_rs_out);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (seed_ready !== 1'b1 || rnd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b required ready=1 valid=0",
               seed_ready, rnd_valid);
    end
    model_reset();
  endtask

  task automatic test_warmup();
    logic [30:0] s;
    s = $urandom;
    do_seed(s, 1'b0);
    n_checks++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_e0: got valid=%b ready=%b required 0 0", rnd_valid, seed_ready);
    end
    // A different seed held during warm-up must be ignored.
    seed_valid = 1'b1;
    seed       = ~s;
    for (int e = 1; e <= W + 1; e++) begin
      en = 1'($urandom);
      tick();
      model_adv();
      n_checks++;
      if (e <= W) begin
        if (rnd_valid !== 1'b0 || seed_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL warm_e%0d: got valid=%b ready=%b required 0 0",
                   e, rnd_valid, seed_ready);
        end
      end else begin
        if (rnd_valid !== 1'b1 || seed_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL warm_done: got valid=%b ready=%b required 1 1", rnd_valid, seed_ready);
        end
      end
    end
    seed_valid = 1'b0;
    en         = 1'b0;
    model_pack();
    n_checks++;
    if (r_out !== exp_r || rs_out !== exp_rs) begin
      n_fail++;
      $display("FAIL first_word: got r=%h rs=%h required r=%h rs=%h", r_out, rs_out, exp_r, exp_rs);
    end
  endtask

  task automatic test_lanes();
    logic [23:0] w [NL];
    int          same;
    for (int l = 0; l < NL; l++) begin
      w[l] = {rs_out[6*l +: 6], r_out[18*l +: 18]};
      n_checks++;
      if (w[l] !== mw[l]) begin
        n_fail++;
        $display("FAIL lane_%0d: got %h required %h", l, w[l], mw[l]);
      end
    end
    same = 0;
    for (int a = 0; a < NL; a++)
      for (int b = a + 1; b < NL; b++)
        if (w[a] == w[b]) same++;
    n_checks++;
    if (same !== 0) begin
      n_fail++;
      $display("FAIL lane_distinct: got %0d equal pairs required 0", same);
    end
  endtask

  task automatic test_run_random();
    for (int c = 0; c < 40; c++) begin
      en = 1'($urandom);
      tick();
      if (en) model_adv();
      model_pack();
      n_checks++;
      if (rnd_valid !== 1'b1 || r_out !== exp_r || rs_out !== exp_rs) begin
        n_fail++;
        $display("FAIL run_cycle_%0d: got valid=%b r=%h rs=%h required valid=1 r=%h rs=%h",
                 c, rnd_valid, r_out, rs_out, exp_r, exp_rs);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_stall();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (rnd_valid !== 1'b1 || r_out !== exp_r || rs_out !== exp_rs) begin
        n_fail++;
        $display("FAIL stall_%0d: got r=%h rs=%h required r=%h rs=%h",
                 c, r_out, rs_out, exp_r, exp_rs);
      end
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    model_adv();
    model_pack();
    n_checks++;
    if (r_out !== exp_r || rs_out !== exp_rs) begin
      n_fail++;
      $display("FAIL stall_pulse: got r=%h rs=%h required r=%h rs=%h", r_out, rs_out, exp_r, exp_rs);
    end
    tick();
    n_checks++;
    if (r_out !== exp_r || rs_out !== exp_rs) begin
      n_fail++;
      $display("FAIL stall_after: got r=%h rs=%h required r=%h rs=%h", r_out, rs_out, exp_r, exp_rs);
    end
  endtask

  task automatic test_reseed_same_edge();
    reseed_val = $urandom;
    seed_valid = 1'b1;
    seed       = reseed_val;
    en         = 1'b1;
    tick();
    seed_valid = 1'b0;
    en         = 1'b0;
    // Words keep the last RUN value; no advance happened on the reseed edge.
    n_checks++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b0 || r_out !== exp_r || rs_out !== exp_rs) begin
      n_fail++;
      $display("FAIL reseed_edge: got valid=%b ready=%b r=%h rs=%h required 0 0 r=%h rs=%h",
               rnd_valid, seed_ready, r_out, rs_out, exp_r, exp_rs);
    end
    model_seed(reseed_val);
    for (int e = 1; e <= W + 1; e++) begin
      tick();
      model_adv();
    end
    for (int c = 0; c < 6; c++) begin
      model_pack();
      cap_r[c]  = r_out;
      cap_rs[c] = rs_out;
      n_checks++;
      if (rnd_valid !== 1'b1 || r_out !== exp_r || rs_out !== exp_rs) begin
        n_fail++;
        $display("FAIL reseed_word_%0d: got valid=%b r=%h rs=%h required 1 r=%h rs=%h",
                 c, rnd_valid, r_out, rs_out, exp_r, exp_rs);
      end
      en = 1'b1;
      tick();
      en = 1'b0;
      model_adv();
    end
  endtask

  task automatic test_midrun_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rnd_valid, seed_ready, r_out, rs_out} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b ready=%b r=%h rs=%h required all 0",
               rnd_valid, seed_ready, r_out, rs_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (seed_ready !== 1'b1 || rnd_valid !== 1'b0 || r_out !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b valid=%b r=%h required 1 0 0",
               seed_ready, rnd_valid, r_out);
    end
    model_reset();
    // Fresh seed from IDLE must reproduce the sequence captured after reseed in RUN.
    do_seed(reseed_val, 1'b0);
    for (int e = 1; e <= W + 1; e++) tick();
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (rnd_valid !== 1'b1 || r_out !== cap_r[c] || rs_out !== cap_rs[c]) begin
        n_fail++;
        $display("FAIL fresh_vs_reseed_%0d: got valid=%b r=%h rs=%h required 1 r=%h rs=%h",
                 c, rnd_valid, r_out, rs_out, cap_r[c], cap_rs[c]);
      end
      en = 1'b1;
      tick();
      en = 1'b0;
    end
  endtask

  task automatic test_zero_lane();
    n_checks++;
    if (s_seed_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL small_ready: got %b required 1", s_seed_ready);
    end
    s_seed_valid = 1'b1;
    s_seed       = 31'h2545F491;
    tick();
    s_seed_valid = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      n_checks++;
      if (s_rnd_valid !== 1'b0 || s_seed_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL small_warm_e%0d: got valid=%b ready=%b required 0 0",
                 e - 1, s_rnd_valid, s_seed_ready);
      end
      tick();
    end
    n_checks++;
    if (s_rnd_valid !== 1'b1 || s_r_out !== 18'h00048 || s_rs_out !== 6'h00) begin
      n_fail++;
      $display("FAIL small_value: got valid=%b r=%h rs=%h required 1 r=00048 rs=00",
               s_rnd_valid, s_r_out, s_rs_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    seed_valid   = 1'b0;
    seed         = '0;
    en           = 1'b0;
    s_seed_valid = 1'b0;
    s_seed       = '0;
    s_en         = 1'b0;
    model_reset();
    test_reset();
    test_warmup();
    test_lanes();
    test_run_random();
    test_stall();
    test_reseed_same_edge();
    test_midrun_reset();
    test_zero_lane();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
